// File: rtl/matrix_loader.sv
// matrix_loader: streams 2*N_ELEM element beats into operand buffers A and B,
// strobes the multiplier, waits for its completion and pulses res_valid.
// Optional watchdog on the WAIT state: define MATRIX_LOADER_TIMEOUT_EN.
// Without it, err is tied low and WAIT lasts until mul_done.
module matrix_loader #(
  parameter int N_ELEM      = 1024,
  parameter int DAT_W       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [DAT_W-1:0]               in_data,
  output logic                           in_ready,
  output logic [N_ELEM-1:0][DAT_W-1:0]   mat_A,
  output logic [N_ELEM-1:0][DAT_W-1:0]   mat_B,
  output logic                           mul_start,
  input  logic                           mul_done,
  output logic                           busy,
  output logic                           res_valid,
  output logic                           err
);

  // A single-element matrix still needs a 1-bit index to stay legal.
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4
  } state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [N_ELEM-1:0][DAT_W-1:0]  mat_a_q, mat_b_q;
  logic                          mul_start_q, busy_q, res_valid_q;
  logic                          in_ready_s, accept_s, we_a_s, we_b_s;
  logic [IDX_W-1:0]              wr_idx_s;
  logic                          timeout_s;

`ifdef MATRIX_LOADER_TIMEOUT_EN
  // One spare bit so the terminal count always fits.
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Watchdog fires only if done did not arrive in the terminal cycle: done wins.
  assign timeout_s = (state_q == S_WAIT) && !mul_done && (cnt_q == LAST_CNT);

  // Counter clears on entry to WAIT and counts WAIT cycles; err is sticky until a beat.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if ((state_q != S_WAIT) && (state_d == S_WAIT)) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (timeout_s) begin
      err_d = 1'b1;
    end else if (accept_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Watchdog counter and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Parameter kept for interface compatibility; no watchdog in this build.
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CYC > 0);
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // State and element index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and index sequencing; idle states hold on in_valid low.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (N_ELEM == 1) begin
            state_d = S_LOAD_B;
            idx_d   = '0;
          end else begin
            state_d = S_LOAD_A;
            idx_d   = IDX_W'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_A: begin
        if (accept_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_B: begin
        if (accept_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_START;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_LOAD_B;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          state_d = S_IDLE;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Handshake and buffer write decode from the current state.
  always_comb begin
    in_ready_s = 1'b0;
    we_a_s     = 1'b0;
    we_b_s     = 1'b0;
    wr_idx_s   = idx_q;
    case (state_q)
      S_IDLE: begin
        in_ready_s = 1'b1;
        wr_idx_s   = '0;
        we_a_s     = in_valid;
      end
      S_LOAD_A: begin
        in_ready_s = 1'b1;
        we_a_s     = in_valid;
      end
      S_LOAD_B: begin
        in_ready_s = 1'b1;
        we_b_s     = in_valid;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
    accept_s = in_valid && in_ready_s;
  end

  // Operand buffers: written one element per accepted beat, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else begin
      if (we_a_s) begin
        mat_a_q[wr_idx_s] <= in_data;
      end
      if (we_b_s) begin
        mat_b_q[wr_idx_s] <= in_data;
      end
    end
  end

  // Registered status outputs derived from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      mul_start_q <= (state_d == S_START);
      busy_q      <= (state_d != S_IDLE);
      res_valid_q <= (state_q == S_WAIT) && mul_done;
    end
  end

  assign in_ready  = in_ready_s;
  assign mat_A     = mat_a_q;
  assign mat_B     = mat_b_q;
  assign mul_start = mul_start_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader with N_ELEM=4, DAT_W=8, TIMEOUT_CYC=16.
module tb_matrix_loader;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [W-1:0]         in_data;
  logic                 in_ready;
  logic [N-1:0][W-1:0]  mat_A;
  logic [N-1:0][W-1:0]  mat_B;
  logic                 mul_start;
  logic                 mul_done;
  logic                 busy;
  logic                 res_valid;
  logic                 err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       dn;
    logic       rdy;
    logic       st;
    logic       bsy;
    logic       rv;
  } vec_t;

  vec_t tbl [12];

  matrix_loader #(.N_ELEM(N), .DAT_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mat_A(mat_A), .mat_B(mat_B), .mul_start(mul_start),
    .mul_done(mul_done), .busy(busy), .res_valid(res_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic rdy, input logic st,
                         input logic bsy, input logic rv, input logic er);
    chk({nm, " in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
    chk({nm, " mul_start"}, {31'd0, mul_start}, {31'd0, st});
    chk({nm, " busy"},      {31'd0, busy},      {31'd0, bsy});
    chk({nm, " res_valid"}, {31'd0, res_valid}, {31'd0, rv});
    chk({nm, " err"},       {31'd0, err},       {31'd0, er});
  endtask

  // Drive inputs, take one rising edge, settle just after it.
  task automatic step(input logic v, input logic [7:0] d, input logic dn);
    in_valid = v;
    in_data  = d;
    mul_done = dn;
    @(posedge clk);
    #1;
  endtask

  // Eight back-to-back beats from IDLE, ending in START.
  task automatic load8(input string nm, input logic [7:0] base);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, base + 8'(k), 1'b0);
      if (k < 7) chk_out($sformatf("%s beat%0d", nm, k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      else       chk_out($sformatf("%s beat%0d", nm, k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    //             v     d      dn    rdy   st    bsy   rv
    tbl[0]  = '{1'b1, 8'd1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'd2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'd3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'd4,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'd5,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 8'd6,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'd7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'd8,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    mul_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset mat_A", mat_A, 32'h0);
    chk("reset mat_B", mat_B, 32'h0);

    // Back-to-back load, mul_done three cycles after mul_start.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].dn);
      chk_out($sformatf("t1[%0d]", i), tbl[i].rdy, tbl[i].st, tbl[i].bsy, tbl[i].rv, 1'b0);
    end
    chk("t1 mat_A", mat_A, 32'h04030201);
    chk("t1 mat_B", mat_B, 32'h08070605);

    // Stalled load (in_valid low every other cycle, mul_done high but ignored).
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 8'h11 + 8'(k), 1'b0);
      if (k < 7) chk_out($sformatf("stall beat%0d", k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      else       chk_out($sformatf("stall beat%0d", k), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 0) begin
        chk("partial mat_A", mat_A, 32'h04030211);
        chk("partial mat_B", mat_B, 32'h08070605);
      end
      if (k < 7) begin
        step(1'b0, 8'h00, 1'b1);
        chk_out($sformatf("stall gap%0d", k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    chk("stall mat_A", mat_A, 32'h14131211);
    chk("stall mat_B", mat_B, 32'h18171615);

    // Beat 0xAA held valid through START/WAIT must not be consumed.
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 8'hAA, 1'b0);
      chk_out($sformatf("hold%0d", c), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("hold%0d mat_A", c), mat_A, 32'h14131211);
    end
    step(1'b1, 8'hAA, 1'b1);
    chk_out("hold done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hold done mat_A", mat_A, 32'h14131211);
    step(1'b1, 8'hAA, 1'b0);
    chk_out("AA accept", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("AA mat_A", mat_A, 32'h141312AA);
    chk("AA mat_B", mat_B, 32'h18171615);

    // Four more beats: five in total, last one lands in mat_B[0].
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'h31 + 8'(k), 1'b0);
    end
    chk_out("beat5", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("beat5 mat_A", mat_A, 32'h333231AA);
    chk("beat5 mat_B", mat_B, 32'h18171634);

    // Asynchronous reset mid-load takes effect before any clock edge.
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk_out("async rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("async rst mat_A", mat_A, 32'h0);
    chk("async rst mat_B", mat_B, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    load8("post-rst", 8'h41);
    step(1'b0, 8'h00, 1'b0);
    chk_out("post-rst wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk_out("post-rst done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post-rst mat_A", mat_A, 32'h44434241);
    chk("post-rst mat_B", mat_B, 32'h48474645);

`ifdef MATRIX_LOADER_TIMEOUT_EN
    // Watchdog: 16 WAIT cycles with no done -> err, IDLE, no res_valid.
    load8("to", 8'h51);
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 8'h00, 1'b0);
      chk_out($sformatf("to wait%0d", c), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0);
    chk_out("to expire", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk_out("to sticky", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h61, 1'b0);
    chk_out("to clear", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      step(1'b1, 8'h61 + 8'(k), 1'b0);
    end
    chk_out("race start", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Done in the terminal WAIT cycle wins over the watchdog.
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 8'h00, 1'b0);
    end
    chk_out("race pre", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk_out("race done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("race mat_A", mat_A, 32'h64636261);
`else
    // Without the watchdog WAIT lasts well past the would-be limit.
    load8("nowd", 8'h51);
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 8'h00, 1'b0);
      chk_out($sformatf("nowd wait%0d", c), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk_out("nowd done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("nowd mat_B", mat_B, 32'h58575655);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 The module SHALL have parameter N_ELEM, default 1024, giving the number of elements per matrix.
REQ-002 The module SHALL have parameter DAT_W, default 8, giving the element width in bits.
REQ-003 The module SHALL have parameter TIMEOUT_CYC, default 4096, giving the watchdog limit in cycles (used only with the watchdog compiled in).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: the reset; it is asynchronous and active-high.
REQ-006 The module SHALL have port in_valid, input, 1 bit: an element beat is offered.
REQ-007 The module SHALL have port in_data, input, DAT_W bits: the offered element.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the loader accepts a beat this cycle.
REQ-009 The module SHALL have port mat_A, output, [N_ELEM-1:0][DAT_W-1:0]: the operand A buffer, driven to the multiplier.
REQ-010 The module SHALL have port mat_B, output, [N_ELEM-1:0][DAT_W-1:0]: the operand B buffer, driven to the multiplier.
REQ-011 The module SHALL have port mul_start, output, 1 bit: the start strobe to the multiplier.
REQ-012 The module SHALL have port mul_done, input, 1 bit: the completion flag from the multiplier.
REQ-013 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The module SHALL have port res_valid, output, 1 bit: a one-cycle pulse indicating that the multiplier result is valid.
REQ-015 The module SHALL have port err, output, 1 bit: the sticky watchdog error flag.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, START and WAIT.
REQ-017 A beat SHALL be accepted only in a cycle where in_valid && in_ready is true.
REQ-018 in_ready SHALL be 1 in IDLE, LOAD_A and LOAD_B, and 0 in START and WAIT.
REQ-019 An index counter idx, $clog2(N_ELEM) bits wide, SHALL address the element written on each accepted beat.
REQ-020 In IDLE, an accepted beat SHALL write mat_A[0], set idx to 1 and move the FSM to LOAD_A (or to LOAD_B with idx 0 when N_ELEM==1).
REQ-021 In LOAD_A, an accepted beat SHALL write mat_A[idx]; on the beat at idx==N_ELEM-1, idx SHALL return to 0 and the FSM SHALL move to LOAD_B, otherwise idx SHALL increment.
REQ-022 In LOAD_B, an accepted beat SHALL write mat_B[idx]; on the beat at idx==N_ELEM-1, idx SHALL return to 0 and the FSM SHALL move to START.
REQ-023 A cycle in IDLE, LOAD_A or LOAD_B with in_valid low SHALL leave the state, idx and the buffers unchanged (stall of any length).
REQ-024 mul_start SHALL be 1 for exactly the single START cycle, registered, and the FSM SHALL then move unconditionally to WAIT.
REQ-025 mul_done SHALL be ignored in IDLE, LOAD_A, LOAD_B and START.
REQ-026 In WAIT with mul_done==1, the FSM SHALL pulse res_valid for one cycle (the cycle after mul_done is sampled) and return to IDLE.
REQ-027 mat_A and mat_B SHALL hold their values through START and WAIT and afterwards, until overwritten by a new load.
REQ-028 Elements not yet rewritten during a new load SHALL keep their previous values.
REQ-029 Beats offered in START or WAIT SHALL NOT be consumed; the upstream holds them per the valid/ready rule.
REQ-030 Minimum latency SHALL be 2*N_ELEM accepted beats, plus 1 START cycle, plus the multiplier time, plus 1 cycle to res_valid.

Reset
REQ-031 Asserting rst, including mid-load or during WAIT, SHALL immediately force state=IDLE, idx=0, in_ready=1 (combinational from IDLE), mul_start=0, res_valid=0, err=0, busy=0, and every element of mat_A and mat_B to 0.
REQ-032 After rst is released, the first accepted beat SHALL start a fresh load at mat_A[0].

Configuration
REQ-033 With macro MATRIX_LOADER_TIMEOUT_EN defined, a cycle counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-034 With MATRIX_LOADER_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYC-1 without mul_done, the FSM SHALL set err=1, return to IDLE and pulse no res_valid.
REQ-035 With MATRIX_LOADER_TIMEOUT_EN defined, err SHALL clear on the next accepted beat or on rst.
REQ-036 With MATRIX_LOADER_TIMEOUT_EN defined, if mul_done arrives in the cycle the counter reaches TIMEOUT_CYC-1, done SHALL win: res_valid SHALL pulse and err SHALL remain 0.
REQ-037 With MATRIX_LOADER_TIMEOUT_EN undefined, the counter SHALL be absent, err SHALL be tied to 0 and WAIT SHALL last indefinitely.

Verification (N_ELEM=4, DAT_W=8, TIMEOUT_CYC=16)
REQ-038 Back-to-back beats 1..8 with mul_done raised 3 cycles after mul_start -> mat_A={4,3,2,1}, mat_B={8,7,6,5}, one mul_start pulse after beat 8, and a res_valid pulse one cycle after mul_done.
REQ-039 The same 8 beats with in_valid low every other cycle -> identical buffer contents, with mul_start one cycle after the 8th accepted beat.
REQ-040 Keeping in_valid=1 with data 0xAA during WAIT -> in_ready=0 and the buffers unchanged; after res_valid, 0xAA is written to mat_A[0].
REQ-041 Asserting rst after beat 5 -> all outputs at reset values and buffers zero; a subsequent 8-beat load completes normally.
REQ-042 With MATRIX_LOADER_TIMEOUT_EN defined and mul_done never raised -> err=1 after 16 WAIT cycles, FSM in IDLE, no res_valid; err clears on the next accepted beat.
REQ-043 With MATRIX_LOADER_TIMEOUT_EN defined and mul_done raised in WAIT cycle 16 -> res_valid=1 and err=0.
